roll_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the nibble prefix-sum ("roll") datapath.
- Takes a 32-bit word over a valid/ready handshake and processes one 4-bit nibble per cycle, LSB nibble first.
- Each output nibble i = (carry_in + nib[0] + … + nib[i]) mod 16.
- Optional chaining carries the running sum across consecutive words, giving a stream-level prefix sum.
- Sits between the operand source and the result consumer.

---
 rtl/roll_pkg.sv | 15 +
 rtl/roll_nib_step.sv | 13 +
 rtl/roll_seq_ctrl.sv | 119 +++++++++++
 tb/tb_roll_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/roll_pkg.sv
// Shared types and geometry for the nibble prefix-sum ("roll") sequencer.
package roll_pkg;

    localparam int NIB_W  = 4;
    localparam int NIB_N  = 8;
    localparam int IDX_W  = $clog2(NIB_N);
    localparam int DATA_W = NIB_W * NIB_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/roll_nib_step.sv
// One prefix-sum step: adds a nibble to the running accumulator, wrapping mod 2**NIB_W.
module roll_nib_step
    import roll_pkg::*;
(
    input  logic [NIB_W-1:0] acc,
    input  logic [NIB_W-1:0] nib,
    output logic [NIB_W-1:0] s
);

    // Same-width addition drops the carry out, which gives the mod-16 wrap.
    assign s = acc + nib;

endmodule

// File: rtl/roll_seq_ctrl.sv
// Sequencer that turns a 32-bit word into its nibble prefix sum, one nibble per cycle,
// with optional carry chaining across consecutive words.
module roll_seq_ctrl
    import roll_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_chain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [NIB_W-1:0]  carry,
    output logic [CNT_W-1:0]  words_done
);

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [NIB_W-1:0]    acc_reg, acc_next;
    logic [DATA_W-1:0]   data_q_reg, data_q_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
    logic [NIB_W-1:0]    carry_reg, carry_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic [NIB_W-1:0]    nib_arr [NIB_N];
    logic [NIB_W-1:0]    nib_cur;
    logic [NIB_W-1:0]    step_s;

    for (genvar gi = 0; gi < NIB_N; gi++) begin : g_nib
        assign nib_arr[gi] = data_q_reg[gi*NIB_W +: NIB_W];
    end

    assign nib_cur = nib_arr[idx_reg];

    roll_nib_step u_step (
        .acc (acc_reg),
        .nib (nib_cur),
        .s   (step_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            acc_reg      <= '0;
            data_q_reg   <= '0;
            out_data_reg <= '0;
            carry_reg    <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            acc_reg      <= acc_next;
            data_q_reg   <= data_q_next;
            out_data_reg <= out_data_next;
            carry_reg    <= carry_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        acc_next      = acc_reg;
        data_q_next   = data_q_reg;
        out_data_next = out_data_reg;
        carry_next    = carry_reg;
        cnt_next      = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_q_next = in_data;
                    acc_next    = in_chain ? carry_reg : '0;
                    idx_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                // Only the current nibble is written; higher ones keep last word's value.
                for (int i = 0; i < NIB_N; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        out_data_next[i*NIB_W +: NIB_W] = step_s;
                    end
                end
                acc_next = step_s;
                idx_next = idx_reg + {{(IDX_W-1){1'b0}}, 1'b1};
                if (idx_reg == IDX_W'(NIB_N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    carry_next = acc_reg;
                    if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign out_data   = out_data_reg;
    assign carry      = carry_reg;
    assign words_done = cnt_reg;

endmodule

// File: tb/tb_roll_seq_ctrl.sv
// Scoreboard bench for roll_seq_ctrl: directed cases plus randomized chained words
// with random consumer backpressure, checked against an arithmetic prefix-sum model.
module tb_roll_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_chain;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [3:0]  carry;
    logic [15:0] words_done;

    roll_seq_ctrl #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_chain   (in_chain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .carry      (carry),
        .words_done (words_done)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  carry_new;
        logic [3:0]  carry_old;
        logic [15:0] count;
        int          acc_cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [3:0]  model_carry = 4'd0;
    logic [15:0] model_count = 16'd0;
    bit          hold = 1'b0;
    bit          bp = 1'b0;
    logic        prev_valid = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: each output nibble is the running sum mod 16 of seed plus nibbles 0..i.
    function automatic logic [35:0] roll_model(input logic [31:0] d, input logic [3:0] seed);
        int          sum;
        logic [31:0] res;
        sum = seed;
        res = 32'd0;
        for (int i = 0; i < 8; i++) begin
            sum = (sum + int'((d >> (4 * i)) & 32'hF)) % 16;
            res = res | (32'(sum) << (4 * i));
        end
        return {4'(sum), res};
    endfunction

    // Consumer model: ready every cycle, random, or held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic send_word(input logic [31:0] d, input logic ch);
        int          n;
        logic [35:0] m;
        exp_t        e;
        n = 0;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                return;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_chain = ch;
        @(posedge clk);
        #1;
        m = roll_model(d, ch ? model_carry : 4'd0);
        e.data      = m[31:0];
        e.carry_old = model_carry;
        e.carry_new = m[35:32];
        if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
        e.count     = model_count;
        e.acc_cycle = cyc;
        model_carry = m[35:32];
        exp_q.push_back(e);
        $display("in  data=%h chain=%0d cycle=%0d", d, ch, cyc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || !in_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                return;
            end
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!prev_valid) chk("latency", 32'(cyc - exp_q[0].acc_cycle), 32'd8);
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.data);
                        $display("out data=%h cycle=%0d", out_data, cyc);
                        @(posedge clk);
                        #1;
                        chk("carry_after_hs", 32'(carry), 32'(e.carry_new));
                        chk("words_done", 32'(words_done), 32'(e.count));
                        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
                        chk("out_valid_after_hs", 32'(out_valid), 32'd0);
                    end else begin
                        chk("stall_data", out_data, exp_q[0].data);
                        chk("stall_carry", 32'(carry), 32'(exp_q[0].carry_old));
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_out_data"},   out_data,        32'd0);
        chk({tag, "_carry"},      32'(carry),      32'd0);
        chk({tag, "_words_done"}, 32'(words_done), 32'd0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_chain = 1'b0;
        #2;
        check_reset_state("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed words: basic, wrap, chaining.
        send_word(32'h11111111, 1'b0);
        send_word(32'hFFFFFFFF, 1'b0);
        send_word(32'h000000FF, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h00000001, 1'b1);
        send_word(32'h00000000, 1'b0);
        drain();

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        hold = 1'b1;
        send_word($urandom, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        hold = 1'b0;
        drain();

        // in_valid pulsed during RUN at idx=3 must be ignored.
        send_word(32'hABCD1234, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_chain = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset at idx=4 discards the word and clears carry/count at once.
        send_word(32'h12345678, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_carry = 4'd0;
        model_count = 16'd0;
        #1;
        check_reset_state("midrun_reset");
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h22222222, 1'b1);
        drain();

        // Randomized chained traffic with random backpressure.
        bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_word($urandom, 1'($urandom_range(0, 1)));
        end
        drain();
        bp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
